// File: rtl/fpu_issue_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_arb_if
// Brief    : Bundled requester, response and FPU-side signals for the
//            two-requester FPU issue arbiter. The slave modport is the
//            arbiter view; the master modport is the requester/FPU view.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_issue_arb_if;
  // Requester side (index 0/1 selects the requester)
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][2:0]   req_rm;
  logic [1:0][6:0]   req_uopc;
  logic [1:0][19:0]  req_imm;
  logic [1:0][64:0]  req_rs1;
  logic [1:0][64:0]  req_rs2;
  logic [1:0][64:0]  req_rs3;
  logic [1:0]        resp_valid;
  logic [1:0][64:0]  resp_data;
  logic [1:0]        resp_fflags_valid;
  logic [1:0][4:0]   resp_fflags;

  // Shared FPU port
  logic              fpu_req_valid;
  logic [2:0]        fpu_req_rm;
  logic [6:0]        fpu_req_uopc;
  logic [19:0]       fpu_req_imm;
  logic [64:0]       fpu_req_rs1;
  logic [64:0]       fpu_req_rs2;
  logic [64:0]       fpu_req_rs3;
  logic              fpu_resp_valid;
  logic [64:0]       fpu_resp_data;
  logic              fpu_resp_fflags_valid;
  logic [4:0]        fpu_resp_fflags;

  // Sticky protocol error
  logic              err;

  modport slave (
    input  req_valid, req_rm, req_uopc, req_imm, req_rs1, req_rs2, req_rs3,
    input  fpu_resp_valid, fpu_resp_data, fpu_resp_fflags_valid, fpu_resp_fflags,
    output req_ready, resp_valid, resp_data, resp_fflags_valid, resp_fflags,
    output fpu_req_valid, fpu_req_rm, fpu_req_uopc, fpu_req_imm,
    output fpu_req_rs1, fpu_req_rs2, fpu_req_rs3,
    output err
  );

  modport master (
    output req_valid, req_rm, req_uopc, req_imm, req_rs1, req_rs2, req_rs3,
    output fpu_resp_valid, fpu_resp_data, fpu_resp_fflags_valid, fpu_resp_fflags,
    input  req_ready, resp_valid, resp_data, resp_fflags_valid, resp_fflags,
    input  fpu_req_valid, fpu_req_rm, fpu_req_uopc, fpu_req_imm,
    input  fpu_req_rs1, fpu_req_rs2, fpu_req_rs3,
    input  err
  );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_arb
// Brief    : Two-requester issue arbiter and response router for a shared,
//            fixed-latency FPU. One grant per cycle, registered FPU request,
//            LAT-deep owner pipeline steering responses back to the issuer.
//            Grants depend only on valids and occupancy counters.
// Config   : define FPU_ARB_RR_EN for round-robin arbitration; otherwise
//            requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_arb #(
  parameter int LAT     = 4,
  parameter int MAX_OUT = 3
) (
  input  wire logic      clock,
  input  wire logic      reset,   // asynchronous, active low
  fpu_issue_arb_if.slave bus
);

  localparam int            CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [1:0]     elig;
  logic [1:0]     grant;
  logic           gnt_id;

  logic           fpu_req_valid_q;
  logic [2:0]     rm_q;
  logic [6:0]     uopc_q;
  logic [19:0]    imm_q;
  logic [64:0]    rs1_q;
  logic [64:0]    rs2_q;
  logic [64:0]    rs3_q;
  logic           iss_own_q;

  logic [LAT-1:0] pipe_v_q;
  logic [LAT-1:0] pipe_own_q;
  logic           tail_v;
  logic           tail_own;

  logic           err_q;

  assign tail_v   = pipe_v_q[LAT-1];
  assign tail_own = pipe_own_q[LAT-1];

  // Per-requester eligibility and in-flight occupancy counter
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          acc;
    logic          ret;

    assign acc      = bus.req_ready[gi];
    assign ret      = tail_v && (tail_own == (gi == 1));
    assign elig[gi] = bus.req_valid[gi] && (cnt_q < MAX_CNT);

    // Accept and retire in the same cycle cancel out
    always_comb begin
      cnt_d = cnt_q;
      if (acc && !ret) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!acc && ret) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // Occupancy counter register
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

`ifdef FPU_ARB_RR_EN
  logic last_q;

  // On a conflict, the requester that did not win most recently is granted
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Remember the most recent winner; reset value lets requester 0 win first
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end
`else
  // Fixed priority: requester 0 wins any conflict
  always_comb begin
    grant = elig[0] ? 2'b01 : elig;
  end
`endif

  assign gnt_id        = grant[1];
  assign bus.req_ready = reset ? grant : 2'b00;

  // Issue register: capture the granted payload, hold it when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpu_req_valid_q <= 1'b0;
      iss_own_q       <= 1'b0;
      rm_q            <= '0;
      uopc_q          <= '0;
      imm_q           <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      rs3_q           <= '0;
    end else begin
      fpu_req_valid_q <= |grant;
      if (|grant) begin
        iss_own_q <= gnt_id;
        rm_q      <= bus.req_rm[gnt_id];
        uopc_q    <= bus.req_uopc[gnt_id];
        imm_q     <= bus.req_imm[gnt_id];
        rs1_q     <= bus.req_rs1[gnt_id];
        rs2_q     <= bus.req_rs2[gnt_id];
        rs3_q     <= bus.req_rs3[gnt_id];
      end
    end
  end

  assign bus.fpu_req_valid = fpu_req_valid_q;
  assign bus.fpu_req_rm    = rm_q;
  assign bus.fpu_req_uopc  = uopc_q;
  assign bus.fpu_req_imm   = imm_q;
  assign bus.fpu_req_rs1   = rs1_q;
  assign bus.fpu_req_rs2   = rs2_q;
  assign bus.fpu_req_rs3   = rs3_q;

  // Owner pipeline: tail lines up with the FPU response of the issued op
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_v_q   <= '0;
      pipe_own_q <= '0;
    end else begin
      pipe_v_q[0]   <= fpu_req_valid_q;
      pipe_own_q[0] <= iss_own_q;
      for (int k = 1; k < LAT; k++) begin
        pipe_v_q[k]   <= pipe_v_q[k-1];
        pipe_own_q[k] <= pipe_own_q[k-1];
      end
    end
  end

  // Steer the FPU response to the tail owner; unmatched responses are dropped
  always_comb begin
    bus.resp_valid        = 2'b00;
    bus.resp_data         = '0;
    bus.resp_fflags_valid = 2'b00;
    bus.resp_fflags       = '0;
    if (bus.fpu_resp_valid && tail_v) begin
      bus.resp_valid[tail_own]        = 1'b1;
      bus.resp_data[tail_own]         = bus.fpu_resp_data;
      bus.resp_fflags_valid[tail_own] = bus.fpu_resp_fflags_valid;
      bus.resp_fflags[tail_own]       = bus.fpu_resp_fflags;
    end
  end

  // Sticky error: response without a tail entry, or tail entry without response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (bus.fpu_resp_valid != tail_v) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_arb
// Brief    : Scoreboard bench for fpu_issue_arb. A driver issues random and
//            directed stimulus, acts as the fixed-latency FPU, and pushes
//            expectations from a transaction-level model; a monitor pops and
//            compares against the DUT outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_arb;
  localparam int LAT     = 4;
  localparam int MAX_OUT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_issue_arb_if bus ();

  fpu_issue_arb #(.LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  rm;
    logic [6:0]  uopc;
    logic [19:0] imm;
    logic [64:0] rs1;
    logic [64:0] rs2;
    logic [64:0] rs3;
  } iss_t;

  typedef struct {
    int          cyc;
    logic        own;
    logic        live;
    logic [64:0] data;
    logic        ffv;
    logic [4:0]  ff;
  } rsp_t;

  typedef struct {
    int         cyc;
    logic [1:0] rdy;
    logic       err;
  } rec_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  rsp_t sched[$];
  rec_t rec_q[$];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cnt_m[2];
  logic last_m   = 1'b1;
  logic err_m    = 1'b0;

  function automatic void check(string name, logic [64:0] act, logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [64:0] rand65();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[64:0];
  endfunction

  // One clock of stimulus plus the reference model update for that cycle
  task automatic drive_cycle(input logic [1:0] v, input logic rst_v, input logic stray,
                             input logic fix_en, input logic [64:0] fix_rs1);
    logic [2:0]  rm   [2];
    logic [6:0]  uopc [2];
    logic [19:0] imm  [2];
    logic [64:0] rs1  [2];
    logic [64:0] rs2  [2];
    logic [64:0] rs3  [2];
    logic [1:0]  elig;
    logic [1:0]  g;
    logic        w;
    logic        due_live;
    iss_t        it;
    rsp_t        r;
    rec_t        rc;

    @(negedge clock);
    cyc++;
    reset = rst_v;
    for (int i = 0; i < 2; i++) begin
      rm[i]   = 3'($urandom());
      uopc[i] = 7'($urandom());
      imm[i]  = 20'($urandom());
      rs1[i]  = (fix_en && i == 0) ? fix_rs1 : rand65();
      rs2[i]  = rand65();
      rs3[i]  = rand65();
      bus.req_valid[i] = v[i];
      bus.req_rm[i]    = rm[i];
      bus.req_uopc[i]  = uopc[i];
      bus.req_imm[i]   = imm[i];
      bus.req_rs1[i]   = rs1[i];
      bus.req_rs2[i]   = rs2[i];
      bus.req_rs3[i]   = rs3[i];
    end

    if (!rst_v) begin
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      last_m   = 1'b1;
      err_m    = 1'b0;
      exp_iss.delete();
      exp_rsp.delete();
      foreach (sched[k]) sched[k].live = 1'b0;
    end

    for (int i = 0; i < 2; i++) elig[i] = rst_v && v[i] && (cnt_m[i] < MAX_OUT);
    if (elig == 2'b11) begin
`ifdef FPU_ARB_RR_EN
      g = last_m ? 2'b01 : 2'b10;
`else
      g = 2'b01;
`endif
    end else begin
      g = elig;
    end
    rc.cyc = cyc;
    rc.rdy = g;
    rc.err = err_m;
    rec_q.push_back(rc);

    due_live                  = 1'b0;
    bus.fpu_resp_valid        = 1'b0;
    bus.fpu_resp_data         = rand65();
    bus.fpu_resp_fflags_valid = 1'($urandom());
    bus.fpu_resp_fflags       = 5'($urandom());
    if (sched.size() > 0 && sched[0].cyc == cyc) begin
      r = sched.pop_front();
      bus.fpu_resp_valid        = 1'b1;
      bus.fpu_resp_data         = r.data;
      bus.fpu_resp_fflags_valid = r.ffv;
      bus.fpu_resp_fflags       = r.ff;
      due_live                  = r.live;
      if (r.live) cnt_m[r.own] = cnt_m[r.own] - 1;
    end else if (stray) begin
      bus.fpu_resp_valid = 1'b1;
    end
    if (rst_v && bus.fpu_resp_valid && !due_live) err_m = 1'b1;

    if (g != 2'b00) begin
      w       = g[1];
      it.cyc  = cyc + 1;
      it.rm   = rm[w];
      it.uopc = uopc[w];
      it.imm  = imm[w];
      it.rs1  = rs1[w];
      it.rs2  = rs2[w];
      it.rs3  = rs3[w];
      exp_iss.push_back(it);
      r.cyc  = cyc + 1 + LAT;
      r.own  = w;
      r.live = 1'b1;
      r.data = rand65();
      r.ffv  = 1'($urandom());
      r.ff   = 5'($urandom());
      exp_rsp.push_back(r);
      sched.push_back(r);
      cnt_m[w] = cnt_m[w] + 1;
      last_m   = w;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 65'd0);
  endtask

  // Monitor: compares DUT outputs against the queued expectations
  initial begin : monitor
    rec_t rc;
    iss_t it;
    rsp_t r;
    forever begin
      @(negedge clock);
      #3;
      if (rec_q.size() > 0 && rec_q[0].cyc == cyc) begin
        rc = rec_q.pop_front();
        check("req_ready", 65'(bus.req_ready), 65'(rc.rdy));
        check("err", 65'(bus.err), 65'(rc.err));
      end
      if (exp_iss.size() > 0 && exp_iss[0].cyc == cyc) begin
        it = exp_iss.pop_front();
        check("fpu_req_valid", 65'(bus.fpu_req_valid), 65'(1'b1));
        check("fpu_req_rm", 65'(bus.fpu_req_rm), 65'(it.rm));
        check("fpu_req_uopc", 65'(bus.fpu_req_uopc), 65'(it.uopc));
        check("fpu_req_imm", 65'(bus.fpu_req_imm), 65'(it.imm));
        check("fpu_req_rs1", bus.fpu_req_rs1, it.rs1);
        check("fpu_req_rs2", bus.fpu_req_rs2, it.rs2);
        check("fpu_req_rs3", bus.fpu_req_rs3, it.rs3);
      end else begin
        check("fpu_req_valid_idle", 65'(bus.fpu_req_valid), 65'(1'b0));
      end
      if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc) begin
        r = exp_rsp.pop_front();
        check("resp_valid", 65'(bus.resp_valid), 65'(r.own ? 2'b10 : 2'b01));
        check("resp_data", bus.resp_data[r.own], r.data);
        check("resp_fflags_valid", 65'(bus.resp_fflags_valid),
              65'(r.own ? {r.ffv, 1'b0} : {1'b0, r.ffv}));
        check("resp_fflags", 65'(bus.resp_fflags[r.own]), 65'(r.ff));
      end else begin
        check("resp_valid_idle", 65'(bus.resp_valid), 65'(2'b00));
        check("resp_fflags_valid_idle", 65'(bus.resp_fflags_valid), 65'(2'b00));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bus.req_valid             = '0;
    bus.req_rm                = '0;
    bus.req_uopc              = '0;
    bus.req_imm               = '0;
    bus.req_rs1               = '0;
    bus.req_rs2               = '0;
    bus.req_rs3               = '0;
    bus.fpu_resp_valid        = 1'b0;
    bus.fpu_resp_data         = '0;
    bus.fpu_resp_fflags_valid = 1'b0;
    bus.fpu_resp_fflags       = '0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;

    // Reset, then confirm the payload registers are cleared
    repeat (3) drive_cycle(2'b11, 1'b0, 1'b0, 1'b0, 65'd0);
    #1;
    check("reset_rs1", bus.fpu_req_rs1, 65'd0);
    check("reset_uopc", 65'(bus.fpu_req_uopc), 65'd0);

    // Single op from requester 0 with a known operand
    drive_cycle(2'b01, 1'b1, 1'b0, 1'b1, 65'h0_3FF0000000000000);
    idle(LAT + 2);

    // Conflict for four cycles
    repeat (4) drive_cycle(2'b11, 1'b1, 1'b0, 1'b0, 65'd0);
    idle(LAT + 8);

    // Requester 1 saturates its in-flight limit and recovers
    repeat (MAX_OUT + LAT + 3) drive_cycle(2'b10, 1'b1, 1'b0, 1'b0, 65'd0);
    idle(LAT + 4);

    // Accept on the same cycle an earlier op retires
    drive_cycle(2'b01, 1'b1, 1'b0, 1'b0, 65'd0);
    idle(LAT);
    repeat (6) drive_cycle(2'b01, 1'b1, 1'b0, 1'b0, 65'd0);
    idle(LAT + 6);

    // Stray response on an empty pipeline
    drive_cycle(2'b00, 1'b1, 1'b1, 1'b0, 65'd0);
    idle(3);

    // Reset with two ops in flight; their late responses are strays
    repeat (2) drive_cycle(2'b01, 1'b1, 1'b0, 1'b0, 65'd0);
    drive_cycle(2'b11, 1'b0, 1'b0, 1'b0, 65'd0);
    #1;
    check("midreset_rs1", bus.fpu_req_rs1, 65'd0);
    check("midreset_imm", 65'(bus.fpu_req_imm), 65'd0);
    idle(LAT + 4);

    // Clean reset, then random traffic
    drive_cycle(2'b00, 1'b0, 1'b0, 1'b0, 65'd0);
    for (int n = 0; n < 300; n++) begin
      drive_cycle({1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                  1'b1, 1'b0, 1'b0, 65'd0);
    end
    idle(LAT + 4);

    @(negedge clock);
    #5;
    check("iss_queue_drained", 65'(exp_iss.size()), 65'd0);
    check("rsp_queue_drained", 65'(exp_rsp.size()), 65'd0);
    check("fpu_sched_drained", 65'(sched.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
